// File: rtl/cpu_reset_stall_ctrl_pkg.sv
// Shared state encoding, default timing values and width helper for the CPU
// reset sequencer / stall controller.
package cpu_reset_stall_ctrl_pkg;

  // state    | meaning
  // ST_HOLD  | CPU held in reset, counting out the reset window
  // ST_RUN   | CPU running, clock-enable follows stall requests
  // ST_STALL | at least one stall request active, watchdog counting
  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } ctrl_state_e;

  localparam int DEF_RESET_CYCLES  = 32;
  localparam int DEF_STALL_TIMEOUT = 255;

  function automatic int cnt_width(input int reset_cycles, input int stall_timeout);
    int max_val;
    max_val = (reset_cycles > stall_timeout) ? reset_cycles : stall_timeout;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_reset_stall_ctrl_sat_counter.sv
// Saturating up-counter shared by the reset window and the stall watchdog.
// Priority: clear > load_one > incr.
module cpu_reset_stall_ctrl_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             load_one,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_ONE;
    end else if (incr && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/cpu_reset_stall_ctrl.sv
// CPU reset sequencer and stall controller: timed reset release, merged stall
// clock-enable, software re-reset and a stall watchdog.
module cpu_reset_stall_ctrl
  import cpu_reset_stall_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int N_STALL       = 2,
  parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_STALL-1:0] stall_req_i,
  input  logic               sw_reset_req_i,
  output logic               reset_n_o,
  output logic               proc_clk_en_o,
  output logic [N_STALL-1:0] stall_src_o,
  output logic               timeout_o,
  output logic [1:0]         state_o
);

  localparam int               CNT_W     = cnt_width(RESET_CYCLES, STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(STALL_TIMEOUT);
  localparam logic             WD_EN     = (STALL_TIMEOUT != 0);

  ctrl_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_clr, cnt_ld, cnt_inc;
  logic               wd_fire;
  logic               stall_any;
  logic               reset_n_q;
  logic               timeout_q;
  logic [N_STALL-1:0] stall_src_q;

  assign stall_any = |stall_req_i;

  cpu_reset_stall_ctrl_sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear    (cnt_clr),
    .load_one (cnt_ld),
    .incr     (cnt_inc),
    .count    (cnt_q)
  );

  // Software reset outranks the watchdog, which outranks stall entry/exit.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    cnt_inc = 1'b0;
    wd_fire = 1'b0;
    if (sw_reset_req_i) begin
      state_d = ST_HOLD;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_RUN: begin
          if (stall_any) begin
            state_d = ST_STALL;
            cnt_ld  = 1'b1;
          end
        end
        ST_STALL: begin
          if (WD_EN && stall_any && (cnt_q == WD_LIMIT)) begin
            state_d = ST_HOLD;
            cnt_clr = 1'b1;
            wd_fire = 1'b1;
          end else if (!stall_any) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_HOLD;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_HOLD;
      reset_n_q   <= 1'b0;
      stall_src_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      reset_n_q <= (state_d != ST_HOLD);
      if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
        stall_src_q <= '0;
      end else if (stall_any) begin
        stall_src_q <= stall_req_i;
      end
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Zero-latency enable: stall_req_i must be driven from clk_i-domain flops.
  assign proc_clk_en_o = reset_n_q & (state_q != ST_HOLD) & ~stall_any;
  assign reset_n_o     = reset_n_q;
  assign stall_src_o   = stall_src_q;
  assign timeout_o     = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cpu_reset_stall_ctrl.sv
// Randomised self-checking bench for cpu_reset_stall_ctrl against a cycle-level
// reference model built from the controller's documented rules.
module tb_cpu_reset_stall_ctrl;

  localparam int RC = 32;
  localparam int NS = 2;
  localparam int ST = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [NS-1:0] stall_req;
  logic          sw;
  logic          reset_n, en, to;
  logic [NS-1:0] src;
  logic [1:0]    state;

  logic [NS-1:0] stall0;
  logic          reset_n0, en0, to0;
  logic [NS-1:0] src0;
  logic [1:0]    state0;

  int errors = 0;
  int checks = 0;

  // reference model: phase 0=HOLD 1=RUN 2=STALL
  int         m_phase;
  int         m_hold_cnt;
  int         m_stall_run;
  bit         m_rstn;
  bit         m_to;
  logic [1:0] m_src;

  cpu_reset_stall_ctrl #(.RESET_CYCLES(RC), .N_STALL(NS), .STALL_TIMEOUT(ST)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_req_i(stall_req), .sw_reset_req_i(sw),
    .reset_n_o(reset_n), .proc_clk_en_o(en), .stall_src_o(src), .timeout_o(to),
    .state_o(state)
  );

  cpu_reset_stall_ctrl #(.RESET_CYCLES(RC), .N_STALL(NS), .STALL_TIMEOUT(0)) dut_nowd (
    .clk_i(clk_i), .reset_i(reset_i), .stall_req_i(stall0), .sw_reset_req_i(sw),
    .reset_n_o(reset_n0), .proc_clk_en_o(en0), .stall_src_o(src0), .timeout_o(to0),
    .state_o(state0)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] exp_vec();
    logic e;
    e = m_rstn && (m_phase != 0) && (stall_req == '0);
    return {m_rstn, e, 2'(m_phase), m_src, m_to};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {reset_n, en, state, src, to};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold_cnt = 0; m_stall_run = 0;
    m_rstn = 1'b0; m_to = 1'b0; m_src = '0;
  endtask

  task automatic model_go_hold();
    m_phase = 0; m_hold_cnt = 0; m_stall_run = 0; m_rstn = 1'b0;
  endtask

  task automatic model_edge();
    bit stalled;
    stalled = (stall_req != '0);
    if (sw) begin
      if (m_phase != 0) m_src = '0;
      else if (stalled) m_src = stall_req;
      model_go_hold();
    end else if (m_phase == 0) begin
      if (stalled) m_src = stall_req;
      m_hold_cnt++;
      if (m_hold_cnt == RC) begin
        m_phase = 1; m_rstn = 1'b1; m_stall_run = 0;
      end
    end else if (stalled) begin
      m_stall_run++;
      if (ST != 0 && m_stall_run == ST + 1) begin
        m_to = 1'b1; m_src = '0;
        model_go_hold();
      end else begin
        m_phase = 2; m_src = stall_req;
      end
    end else begin
      m_phase = 1; m_stall_run = 0;
    end
  endtask

  task automatic apply(input logic [1:0] s, input logic w);
    stall_req = s;
    sw = w;
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; stall_req = '0; sw = 1'b0; stall0 = '0;
    model_reset();
    #2;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", obs_vec(), exp_vec());
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_hold_release();
    for (int i = 0; i < RC; i++) begin
      apply(2'($urandom_range(0, 3)), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_window cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    apply(2'b00, 1'b0);
    checks++;
    if ({reset_n, en, state} !== {1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL hold_release got rstn/en/state=%b exp=1101", {reset_n, en, state});
    end
    tick();
  endtask

  task automatic test_short_stall();
    logic [1:0] pat [12] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00,
                             2'b01, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 12; i++) begin
      apply(pat[i], 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL short_stall cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 60; i++) begin
      apply((i < 20) ? 2'b01 : 2'b00, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL watchdog cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    apply(2'b00, 1'b0);
    checks++;
    if ({to, reset_n, state} !== {1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL watchdog_sticky got to/rstn/state=%b exp=1101", {to, reset_n, state});
    end
    tick();
  endtask

  task automatic test_sw_reset();
    for (int i = 0; i < 9; i++) begin
      apply(2'b01, (i == 8));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sw_vs_watchdog cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    for (int i = 0; i < 61; i++) begin
      apply(2'b00, (i == 20));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sw_hold_restart cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      tick();
    end
    apply(2'b00, 1'b0);
    checks++;
    if ({to, reset_n} !== 2'b01) begin
      errors++;
      $display("FAIL sw_no_timeout got to/rstn=%b exp=01", {to, reset_n});
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply(2'b01, 1'b0);
    tick();
    apply(2'b01, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_async_stall got=%b exp=%b", obs_vec(), exp_vec());
    end
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", obs_vec(), exp_vec());
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    stall_req = '0;
  endtask

  task automatic test_random();
    int cyc = 0;
    for (int b = 0; b < 40; b++) begin
      int len;
      logic [1:0] val;
      len = $urandom_range(1, 14);
      val = 2'($urandom_range(1, 3));
      for (int i = 0; i < len + 3; i++) begin
        apply((i < len) ? val : 2'b00, ($urandom_range(0, 63) == 0));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
        end
        tick();
        cyc++;
      end
    end
  endtask

  task automatic test_no_watchdog();
    for (int i = 0; i < 1000; i++) begin
      stall0 = 2'b11;
      apply(2'b00, 1'b0);
      checks++;
      if ({en0, to0, reset_n0, state0} !== {1'b0, 1'b0, 1'b1, ((i == 0) ? 2'd1 : 2'd2)}) begin
        errors++;
        $display("FAIL no_watchdog cyc=%0d got en/to/rstn/state=%b", i,
                 {en0, to0, reset_n0, state0});
      end
      tick();
    end
    stall0 = 2'b00;
    apply(2'b00, 1'b0);
    checks++;
    if ({en0, state0, src0} !== {1'b1, 2'd2, 2'b11}) begin
      errors++;
      $display("FAIL no_watchdog_release got en/state/src=%b exp=11011", {en0, state0, src0});
    end
    tick();
    apply(2'b00, 1'b0);
    checks++;
    if (state0 !== 2'd1) begin
      errors++;
      $display("FAIL no_watchdog_run got state=%0d exp=1", state0);
    end
    tick();
  endtask

  initial begin
    reset_i = 1'b1; stall_req = '0; sw = 1'b0; stall0 = '0;
    test_reset();
    test_hold_release();
    test_short_stall();
    test_watchdog();
    test_reset();
    test_hold_release();
    test_sw_reset();
    test_async_reset();
    test_hold_release();
    test_random();
    test_reset();
    test_hold_release();
    test_no_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
